fp_operand_loader: RTL and testbench

//  Upstream feeder for the single-precision adder unit. Builds the two 32-bit IEEE-754

---
 rtl/fp_operand_loader.sv | 138 +++++++++++++
 tb/tb_fp_operand_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_loader.sv
// Byte-serial loader for two IEEE-754 single-precision operands: debounced switch/button
// entry, A then B, MSB first, presented as a registered pair with a valid/ack handshake.
module fp_operand_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  sw,
   input  logic        btn_load,
   input  logic        btn_clear,
   input  logic        operands_ack,
   output logic [31:0] dataA,
   output logic [31:0] dataB,
   output logic        operands_valid,
   output logic [2:0]  byte_idx
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StLoadA, StLoadB, StValid} state_e;

   // Index 0 = load button, index 1 = clear button.
   logic [1:0]      raw;
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      stable_q, stable_d;
   logic [1:0]      prev_q, pulse_q;
   logic [CntW-1:0] cnt_q [2];
   logic [CntW-1:0] cnt_d [2];
   logic            load_p, clear_p;

   assign raw     = {btn_clear, btn_load};
   assign load_p  = pulse_q[0];
   assign clear_p = pulse_q[1];

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         pulse_q  <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         // Rising edge of the accepted level only; releases make no pulse.
         pulse_q  <= stable_q & ~prev_q;
         for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] sha_q, sha_d, shb_q, shb_d;
   logic [31:0] data_a_q, data_a_d, data_b_q, data_b_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sha_d    = sha_q;
      shb_d    = shb_q;
      data_a_d = data_a_q;
      data_b_d = data_b_q;
      if (clear_p) begin
         state_d = StLoadA;
         idx_d   = 3'd0;
         sha_d   = '0;
         shb_d   = '0;
      end else begin
         unique case (state_q)
            StLoadA: begin
               if (load_p) begin
                  sha_d = {sha_q[23:0], sw};
                  idx_d = idx_q + 3'd1;
                  if (idx_q == 3'd3) state_d = StLoadB;
               end
            end
            StLoadB: begin
               if (load_p) begin
                  shb_d = {shb_q[23:0], sw};
                  idx_d = idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     data_a_d = sha_q;
                     data_b_d = {shb_q[23:0], sw};
                     state_d  = StValid;
                  end
               end
            end
            StValid: begin
               if (operands_ack) state_d = StLoadA;
            end
            default: state_d = StLoadA;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StLoadA;
         idx_q    <= 3'd0;
         sha_q    <= '0;
         shb_q    <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sha_q    <= sha_d;
         shb_q    <= shb_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
      end
   end

   assign dataA          = data_a_q;
   assign dataB          = data_b_q;
   assign operands_valid = (state_q == StValid);
   assign byte_idx       = idx_q;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader with a short debounce window.
module tb_fp_operand_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  sw = 8'h00;
   logic        btn_load = 1'b0;
   logic        btn_clear = 1'b0;
   logic        operands_ack = 1'b0;
   logic [31:0] dataA, dataB;
   logic        operands_valid;
   logic [2:0]  byte_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .sw             (sw),
      .btn_load       (btn_load),
      .btn_clear      (btn_clear),
      .operands_ack   (operands_ack),
      .dataA          (dataA),
      .dataB          (dataB),
      .operands_valid (operands_valid),
      .byte_idx       (byte_idx)
   );

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic press_load(input logic [7:0] b);
      @(negedge clk);
      sw = b;
      btn_load = 1'b1;
      wait_cycles(10);
      btn_load = 1'b0;
      wait_cycles(10);
   endtask

   task automatic press_clear();
      @(negedge clk);
      btn_clear = 1'b1;
      wait_cycles(10);
      btn_clear = 1'b0;
      wait_cycles(10);
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      operands_ack = 1'b1;
      @(negedge clk);
      operands_ack = 1'b0;
   endtask

   task automatic enter8(input logic [63:0] v);
      for (int i = 0; i < 8; i++) press_load(v[63-8*i -: 8]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_cycles(3);
      checks++;
      if ({dataA, dataB, operands_valid, byte_idx} !== 68'h0) begin
         errors++;
         $display("FAIL reset_state: got A=%h B=%h v=%b idx=%0d, want all zero",
                  dataA, dataB, operands_valid, byte_idx);
      end
      reset = 1'b0;
      wait_cycles(2);
   endtask

   task automatic test_basic_entry();
      int n;
      // Latency: press at a negedge, idx updates after the 8th rising edge.
      @(negedge clk);
      sw = 8'h40;
      btn_load = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (byte_idx != 3'd0 && n == 0) n = i;
      end
      btn_load = 1'b0;
      wait_cycles(10);
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL press_latency: got %0d cycles, want 8", n);
      end
      press_load(8'hE0);
      press_load(8'h00);
      press_load(8'h00);
      checks++;
      if (byte_idx !== 3'd4 || operands_valid !== 1'b0) begin
         errors++;
         $display("FAIL idx_after_A: got idx=%0d v=%b, want idx=4 v=0", byte_idx, operands_valid);
      end
      press_load(8'hC0);
      press_load(8'h88);
      press_load(8'h00);
      press_load(8'h00);
      checks++;
      if (dataA !== 32'h40E00000 || dataB !== 32'hC0880000 || operands_valid !== 1'b1
          || byte_idx !== 3'd0) begin
         errors++;
         $display("FAIL basic_pair: got A=%h B=%h v=%b idx=%0d, want 40e00000 c0880000 1 0",
                  dataA, dataB, operands_valid, byte_idx);
      end
      pulse_ack();
      checks++;
      if (operands_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_ack: got v=%b, want 0", operands_valid);
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      sw = 8'h55;
      btn_load = 1'b1;
      wait_cycles(3);
      btn_load = 1'b0;
      wait_cycles(12);
      checks++;
      if (byte_idx !== 3'd0) begin
         errors++;
         $display("FAIL glitch_reject: got idx=%0d, want 0", byte_idx);
      end
      btn_load = 1'b1;
      wait_cycles(1);
      btn_load = 1'b0;
      wait_cycles(1);
      btn_load = 1'b1;
      wait_cycles(10);
      btn_load = 1'b0;
      wait_cycles(10);
      checks++;
      if (byte_idx !== 3'd1) begin
         errors++;
         $display("FAIL bounce_single: got idx=%0d, want 1", byte_idx);
      end
   endtask

   task automatic test_clear();
      press_load(8'h11);
      press_load(8'h22);
      checks++;
      if (byte_idx !== 3'd3) begin
         errors++;
         $display("FAIL pre_clear_idx: got idx=%0d, want 3", byte_idx);
      end
      press_clear();
      checks++;
      if (byte_idx !== 3'd0 || operands_valid !== 1'b0 || dataA !== 32'h40E00000
          || dataB !== 32'hC0880000) begin
         errors++;
         $display("FAIL clear_state: got idx=%0d v=%b A=%h B=%h, want 0 0 40e00000 c0880000",
                  byte_idx, operands_valid, dataA, dataB);
      end
      enter8(64'h3F800000_3F800000);
      checks++;
      if (dataA !== 32'h3F800000 || dataB !== 32'h3F800000 || operands_valid !== 1'b1) begin
         errors++;
         $display("FAIL clear_reload: got A=%h B=%h v=%b, want 3f800000 3f800000 1",
                  dataA, dataB, operands_valid);
      end
   endtask

   task automatic test_valid_ignore();
      press_load(8'hFF);
      checks++;
      if (dataA !== 32'h3F800000 || dataB !== 32'h3F800000 || byte_idx !== 3'd0
          || operands_valid !== 1'b1) begin
         errors++;
         $display("FAIL valid_ignore: got A=%h B=%h idx=%0d v=%b, want 3f800000 3f800000 0 1",
                  dataA, dataB, byte_idx, operands_valid);
      end
      pulse_ack();
      checks++;
      if (operands_valid !== 1'b0) begin
         errors++;
         $display("FAIL ack_drop: got v=%b, want 0", operands_valid);
      end
      // Extra idle ack outside VALID must be harmless.
      pulse_ack();
      enter8(64'h12345678_9ABCDEF0);
      checks++;
      if (dataA !== 32'h12345678 || dataB !== 32'h9ABCDEF0 || operands_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_ack_pair: got A=%h B=%h v=%b, want 12345678 9abcdef0 1",
                  dataA, dataB, operands_valid);
      end
      pulse_ack();
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 6; i++) press_load(8'hA0 + 8'(i));
      checks++;
      if (byte_idx !== 3'd6) begin
         errors++;
         $display("FAIL pre_simul_idx: got idx=%0d, want 6", byte_idx);
      end
      @(negedge clk);
      sw = 8'h77;
      btn_load = 1'b1;
      btn_clear = 1'b1;
      wait_cycles(10);
      btn_load = 1'b0;
      btn_clear = 1'b0;
      wait_cycles(10);
      checks++;
      if (byte_idx !== 3'd0 || operands_valid !== 1'b0 || dataA !== 32'h12345678
          || dataB !== 32'h9ABCDEF0) begin
         errors++;
         $display("FAIL simul_clear: got idx=%0d v=%b A=%h B=%h, want 0 0 12345678 9abcdef0",
                  byte_idx, operands_valid, dataA, dataB);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) press_load(8'h5A);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({dataA, dataB, operands_valid, byte_idx} !== 68'h0) begin
         errors++;
         $display("FAIL reset_mid: got A=%h B=%h v=%b idx=%0d, want all zero",
                  dataA, dataB, operands_valid, byte_idx);
      end
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(2);
      enter8(64'h41200000_C1A00000);
      checks++;
      if (dataA !== 32'h41200000 || dataB !== 32'hC1A00000 || operands_valid !== 1'b1
          || byte_idx !== 3'd0) begin
         errors++;
         $display("FAIL post_reset_pair: got A=%h B=%h v=%b idx=%0d, want 41200000 c1a00000 1 0",
                  dataA, dataB, operands_valid, byte_idx);
      end
   endtask

   initial begin
      test_reset();
      test_basic_entry();
      test_glitch();
      test_clear();
      test_valid_ignore();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
